relu_frame_sequencer: RTL and testbench

//  Sequences the pixel stream that feeds the activation (ReLu) stage: counts raw valid beats

---
 rtl/relu_frame_sequencer_if.sv | 36 +++
 rtl/relu_frame_sequencer.sv | 170 +++++++++++++++++
 tb/tb_relu_frame_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/relu_frame_sequencer_if.sv
// Pixel stream bundle between the upstream source, the frame sequencer and the ReLu stage.
// The master drives raw beats and observes the marked stream; the slave is the sequencer.
interface relu_frame_sequencer_if #(
   parameter int DATA_WIDTH = 8
);
   logic signed [DATA_WIDTH-1:0] data_i;
   logic                         valid_i;
   logic signed [DATA_WIDTH-1:0] data_o;
   logic                         valid_o;
   logic                         sop_o;
   logic                         eop_o;
   logic                         sof_o;
   logic                         eof_o;

   modport master (
      output data_i,
      output valid_i,
      input  data_o,
      input  valid_o,
      input  sop_o,
      input  eop_o,
      input  sof_o,
      input  eof_o
   );

   modport slave (
      input  data_i,
      input  valid_i,
      output data_o,
      output valid_o,
      output sop_o,
      output eop_o,
      output sof_o,
      output eof_o
   );
endinterface

// File: rtl/relu_frame_sequencer.sv
// Counts accepted pixel beats into IMG_WIDTH x IMG_HEIGHT frames and emits line/frame
// markers one cycle later; frames run single-shot or back-to-back once armed by start_i.
module relu_frame_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic                     continuous_i,
   input  logic                     stop_i,
   relu_frame_sequencer_if.slave    pix,
   output logic                     busy_o,
   output logic                     frame_done_o,
   output logic [CNT_WIDTH-1:0]     frame_cnt_o,
   output logic                     drop_o
);

   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [COL_W-1:0]     COL_ZERO = {COL_W{1'b0}};
   localparam logic [ROW_W-1:0]     ROW_ZERO = {ROW_W{1'b0}};
   localparam logic [COL_W-1:0]     COL_ONE  = COL_W'(1'b1);
   localparam logic [ROW_W-1:0]     ROW_ONE  = ROW_W'(1'b1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
   localparam logic [COL_W-1:0]     COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                       state_q, state_d;
   logic [COL_W-1:0]             col_q, col_d;
   logic [ROW_W-1:0]             row_q, row_d;
   logic                         cont_q, cont_d;
   logic                         drop_q, drop_d;
   logic signed [DATA_WIDTH-1:0] data_q, data_d;
   logic                         valid_q, valid_d;
   logic                         sop_q, sop_d;
   logic                         eop_q, eop_d;
   logic                         sof_q, sof_d;
   logic                         eof_q, eof_d;
   logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

   logic last_col_s;
   logic last_row_s;
   logic cont_keep_s;

   assign last_col_s  = (col_q == COL_LAST);
   assign last_row_s  = (row_q == ROW_LAST);
   // A stop pulse cancels continuous mode but lets the frame in flight finish.
   assign cont_keep_s = cont_q & ~stop_i;

   // Next-state, beat counters and marker generation.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      cont_d  = cont_q;
      drop_d  = drop_q;
      data_d  = data_q;
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               cont_d  = continuous_i & ~stop_i;
               col_d   = COL_ZERO;
               row_d   = ROW_ZERO;
               drop_d  = 1'b0;
            end else if (pix.valid_i) begin
               drop_d = 1'b1;
            end else begin
               drop_d = drop_q;
            end
         end

         ST_RUN: begin
            cont_d = cont_keep_s;
            if (pix.valid_i) begin
               data_d  = pix.data_i;
               valid_d = 1'b1;
               sop_d   = (col_q == COL_ZERO);
               eop_d   = last_col_s;
               sof_d   = (col_q == COL_ZERO) && (row_q == ROW_ZERO);
               eof_d   = last_col_s && last_row_s;
               if (last_col_s) begin
                  col_d = COL_ZERO;
                  if (last_row_s) begin
                     row_d = ROW_ZERO;
                     cnt_d = cnt_q + CNT_ONE;
                     if (cont_keep_s) begin
                        state_d = ST_RUN;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     row_d = row_q + ROW_ONE;
                  end
               end else begin
                  col_d = col_q + COL_ONE;
               end
            end else begin
               data_d = data_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
            col_d   = COL_ZERO;
            row_d   = ROW_ZERO;
            cont_d  = 1'b0;
         end
      endcase
   end

   // State, counters and registered stream outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         col_q   <= COL_ZERO;
         row_q   <= ROW_ZERO;
         cont_q  <= 1'b0;
         drop_q  <= 1'b0;
         data_q  <= {DATA_WIDTH{1'b0}};
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         cnt_q   <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         cont_q  <= cont_d;
         drop_q  <= drop_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pix.data_o   = data_q;
   assign pix.valid_o  = valid_q;
   assign pix.sop_o    = sop_q;
   assign pix.eop_o    = eop_q;
   assign pix.sof_o    = sof_q;
   assign pix.eof_o    = eof_q;
   assign busy_o       = (state_q == ST_RUN);
   assign frame_done_o = eof_q;
   assign frame_cnt_o  = cnt_q;
   assign drop_o       = drop_q;

endmodule

// File: tb/tb_relu_frame_sequencer.sv
// Directed bench for relu_frame_sequencer with a 4x2 frame; a second instance with a
// 2-bit frame counter shares the stimulus to exercise counter wrap.
module tb_relu_frame_sequencer;

   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start_i;
   logic        continuous_i;
   logic        stop_i;
   logic        busy_a, done_a, drop_a;
   logic        busy_b, done_b, drop_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   relu_frame_sequencer_if #(.DATA_WIDTH(DW)) if_a ();
   relu_frame_sequencer_if #(.DATA_WIDTH(DW)) if_b ();

   assign if_b.data_i  = if_a.data_i;
   assign if_b.valid_i = if_a.valid_i;

   relu_frame_sequencer #(
      .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2), .CNT_WIDTH(16)
   ) dut_a (
      .clk(clk), .reset(reset), .start_i(start_i), .continuous_i(continuous_i),
      .stop_i(stop_i), .pix(if_a), .busy_o(busy_a), .frame_done_o(done_a),
      .frame_cnt_o(cnt_a), .drop_o(drop_a)
   );

   relu_frame_sequencer #(
      .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2), .CNT_WIDTH(2)
   ) dut_b (
      .clk(clk), .reset(reset), .start_i(start_i), .continuous_i(continuous_i),
      .stop_i(stop_i), .pix(if_b), .busy_o(busy_b), .frame_done_o(done_b),
      .frame_cnt_o(cnt_b), .drop_o(drop_b)
   );

   int checks   = 0;
   int failures = 0;

   // Hand-computed marker patterns for beats 1..8 of a 4x2 frame (bit k-1 = beat k).
   logic [7:0] sop_tab = 8'b0001_0001;
   logic [7:0] eop_tab = 8'b1000_1000;
   logic [7:0] sof_tab = 8'b0000_0001;
   logic [7:0] eof_tab = 8'b1000_0000;
   int         gaps [8] = '{2, 0, 3, 1, 0, 2, 3, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d);
      if_a.valid_i = 1'b1;
      if_a.data_i  = DW'(d);
      tick();
      if_a.valid_i = 1'b0;
   endtask

   task automatic check_beat(input string tag, input int k, input int d);
      chk({tag, "_valid"}, if_a.valid_o, 1'b1);
      chk({tag, "_data"},  if_a.data_o,  d);
      chk({tag, "_sop"},   if_a.sop_o,   sop_tab[k-1]);
      chk({tag, "_eop"},   if_a.eop_o,   eop_tab[k-1]);
      chk({tag, "_sof"},   if_a.sof_o,   sof_tab[k-1]);
      chk({tag, "_eof"},   if_a.eof_o,   eof_tab[k-1]);
      chk({tag, "_done"},  done_a,       eof_tab[k-1]);
   endtask

   task automatic arm(input logic cont, input logic stp);
      start_i      = 1'b1;
      continuous_i = cont;
      stop_i       = stp;
      tick();
      start_i      = 1'b0;
      continuous_i = 1'b0;
      stop_i       = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      start_i      = 1'b0;
      continuous_i = 1'b0;
      stop_i       = 1'b0;
      if_a.valid_i = 1'b0;
      if_a.data_i  = '0;
      tick();
      tick();
      chk("rst_valid", if_a.valid_o, 1'b0);
      chk("rst_data",  if_a.data_o,  8'h00);
      chk("rst_busy",  busy_a,       1'b0);
      chk("rst_cnt",   cnt_a,        16'd0);
      chk("rst_drop",  drop_a,       1'b0);
      chk("rst_cnt_b", cnt_b,        2'd0);
      reset = 1'b0;

      // Single-shot frame, back-to-back beats 1..8.
      arm(1'b0, 1'b0);
      chk("t1_busy_armed", busy_a, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         drive(k);
         check_beat("t1", k, k);
         chk("t1_busy", busy_a, (k < 8));
      end
      chk("t1_cnt", cnt_a, 16'd1);
      tick();
      chk("t1_idle_valid", if_a.valid_o, 1'b0);
      chk("t1_idle_hold",  if_a.data_o,  8'd8);

      // Same frame with idle gaps and negative data.
      arm(1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         for (int g = 0; g < gaps[k-1]; g++) begin
            tick();
            chk("t2_gap_valid", if_a.valid_o, 1'b0);
            chk("t2_gap_busy",  busy_a,       1'b1);
         end
         drive(-k);
         check_beat("t2", k, -k);
      end
      chk("t2_cnt",  cnt_a,  16'd2);
      chk("t2_busy", busy_a, 1'b0);

      // Beats while idle are dropped; start clears the sticky flag.
      for (int k = 0; k < 3; k++) begin
         drive(85);
         chk("t3_idle_valid", if_a.valid_o, 1'b0);
      end
      chk("t3_drop_set", drop_a, 1'b1);
      if_a.valid_i = 1'b1;
      if_a.data_i  = DW'(99);
      arm(1'b0, 1'b0);
      if_a.valid_i = 1'b0;
      chk("t3_drop_clr",    drop_a,       1'b0);
      chk("t3_start_valid", if_a.valid_o, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         drive(10 + k);
         check_beat("t3", k, 10 + k);
      end
      chk("t3_cnt", cnt_a, 16'd3);

      // Continuous run with stop during beat 10: frames 1 and 2 complete.
      arm(1'b1, 1'b0);
      for (int i = 1; i <= 24; i++) begin
         stop_i = (i == 10);
         drive(i);
         stop_i = 1'b0;
         chk("t4_valid", if_a.valid_o, (i <= 16));
         chk("t4_busy",  busy_a,       (i < 16));
         if (i <= 16) begin
            chk("t4_data", if_a.data_o, i);
            chk("t4_eof",  if_a.eof_o,  ((i % 8) == 0));
         end else begin
            chk("t4_hold", if_a.data_o, 8'd16);
         end
      end
      chk("t4_cnt",    cnt_a,  16'd5);
      chk("t4_drop",   drop_a, 1'b1);
      chk("t4_drop_b", drop_b, 1'b1);

      // Reset on beat 5 aborts the frame; restart with start+stop is single-shot.
      arm(1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         drive(k);
         check_beat("t5a", k, k);
      end
      reset = 1'b1;
      drive(5);
      reset = 1'b0;
      chk("t5_rst_valid", if_a.valid_o, 1'b0);
      chk("t5_rst_sop",   if_a.sop_o,   1'b0);
      chk("t5_rst_eof",   if_a.eof_o,   1'b0);
      chk("t5_rst_data",  if_a.data_o,  8'd0);
      chk("t5_rst_busy",  busy_a,       1'b0);
      chk("t5_rst_cnt",   cnt_a,        16'd0);
      chk("t5_rst_drop",  drop_a,       1'b0);
      arm(1'b1, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         drive(20 + k);
         check_beat("t5b", k, 20 + k);
      end
      chk("t5_cnt",  cnt_a,  16'd1);
      chk("t5_busy", busy_a, 1'b0);

      // Four continuous frames: 2-bit counter wraps, start in RUN ignored, stop on last beat.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      arm(1'b1, 1'b0);
      for (int i = 1; i <= 32; i++) begin
         start_i = (i == 12);
         stop_i  = (i == 32);
         drive(i);
         start_i = 1'b0;
         stop_i  = 1'b0;
         chk("t6_busy", busy_a, (i < 32));
         if ((i % 8) == 0) begin
            chk("t6_cnt_a",  cnt_a,  i / 8);
            chk("t6_cnt_b",  cnt_b,  (i / 8) % 4);
            chk("t6_done_b", done_b, 1'b1);
         end else begin
            chk("t6_eof_b", if_b.eof_o, 1'b0);
         end
      end
      chk("t6_busy_b", busy_b, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
